frame_buffer_scheduler: RTL and testbench
=========================================

// Module: frame_buffer_scheduler
// PURPOSE
//  Triple-buffer scheduler for the DDR frame store shared by the camera-side AXI4 writer and the HDMI-side AXI4 reader.
//  Tracks the buffer being written, the newest complete buffer and the buffer being displayed, and never lets them collide.
//  Drives the frame base addresses consumed by both AXI masters.
//  Counts dropped frames (writer faster than display) and repeated frames (display faster than writer).
// PARAMETERS
//  BASE_ADDR     32'h1000_0000  byte address of buffer 0
//  FRAME_STRIDE  32'h0004_0000  byte distance between buffers (>= 320*240*2)
//  CNT_W         16             width of the status counters
// PORTS
//  clk_100Mhz      in   1      AXI/system clock; all logic on its rising edge
//  rst_n           in   1      synchronous reset, active-low
//  wr_frame_start  in   1      1-cycle pulse: writer begins a frame
//  wr_frame_done   in   1      1-cycle pulse: writer's last burst response received
//  rd_vsync        in   1      1-cycle pulse, already synchronised: display frame boundary
//  wr_base_addr    out  32     FRAME_BASE_ADDR for the writer
//  rd_base_addr    out  32     FRAME_BASE_ADDR for the reader
//  wr_buf_idx      out  2      buffer being written (0..2)
//  rd_buf_idx      out  2      buffer being displayed (0..2)
//  wr_busy         out  1      1 while the writer FSM is in W_ACTIVE
//  latest_valid    out  1      an unconsumed complete frame exists
//  frames_dropped  out  CNT_W  saturating count of discarded frames
//  frames_repeated out  CNT_W  saturating count of vsyncs with no new frame
// BEHAVIOUR
//  State registers:
//   - rd_idx, lt_idx (latest), wr_idx, latest_valid, writer FSM.
//   - Invariant: rd_idx, lt_idx and wr_idx are always pairwise distinct.
//  Reset (rst_n=0 at a rising edge; overrides everything, including mid-frame):
//   - rd_idx=0, lt_idx=1, wr_idx=2, latest_valid=0, FSM=W_IDLE, wr_busy=0.
//   - Both counters 0.
//   - wr_base_addr=BASE+2*STRIDE, rd_base_addr=BASE.
//  Addresses:
//   - base_addr = BASE_ADDR + idx*FRAME_STRIDE, computed mod 2^32.
//   - Registered; updated 1 cycle after the causing pulse, together with the *_buf_idx outputs.
//  Reader side (any FSM state), on rd_vsync:
//   - latest_valid=1: rd_idx<=lt_idx, lt_idx<=old rd_idx, latest_valid<=0.
//   - latest_valid=0: no change; frames_repeated+1.
//  Writer FSM:
//   - W_IDLE, on wr_frame_start: wr_idx <= 3 - rd_idx_next - lt_idx_next, where *_next are the values after any same-cycle reader swap. Go to W_ACTIVE.
//   - W_ACTIVE, on wr_frame_done: lt_idx<=wr_idx, latest_valid<=1. If latest_valid was already 1, frames_dropped+1. Go to W_IDLE.
//   - W_ACTIVE, on wr_frame_start (done missing): discard the partial frame, keep wr_idx, stay in W_ACTIVE, frames_dropped+1.
//   - Ignored pulses: wr_frame_done in W_IDLE; wr_frame_start and wr_frame_done together in W_IDLE (treated as start only).
//  wr_frame_done and rd_vsync in the same cycle:
//   - The reader takes the just-completed frame: rd_idx<=wr_idx, lt_idx<=old rd_idx, latest_valid<=0.
//   - If latest_valid was 1, frames_dropped+1.
//   - Writer goes to W_IDLE; frames_repeated unchanged.
//  Counters saturate at all-ones and never wrap.
//  A buffer index register never holds 3.
// TESTING
//  1 Hold rst_n=0 two cycles -> rd_base=0x1000_0000, wr_base=0x1008_0000, latest_valid=0, both counters 0.
//  2 start, done, vsync -> rd_buf_idx=2, rd_base=0x1008_0000, latest_valid=0. Next start -> wr_buf_idx=1, wr_base=0x1004_0000.
//  3 After reset, vsync x2 with no done -> frames_repeated=2, rd_buf_idx stays 0.
//  4 start/done twice (idx 2, then 1), then vsync -> frames_dropped=1, rd_buf_idx=1, rd_base=0x1004_0000.
//  5 start; done and vsync in the same cycle -> rd_buf_idx=2, latest_valid=0, no counter change. Next start -> wr_buf_idx=1.
//  6 start, start again without done -> frames_dropped=1, wr_buf_idx stays 2. rst_n=0 mid-frame -> test 1 values, wr_busy=0.

Source files
------------

// File: rtl/frame_buffer_scheduler.sv
// frame_buffer_scheduler
//   Triple-buffer scheduler for the DDR frame store shared by the camera-side
//   writer and the HDMI-side reader. Keeps the write, latest-complete and
//   display buffers pairwise distinct and drives the frame base addresses.
// Ports
//   clk_100Mhz      system clock, rising edge
//   rst_n           synchronous active-low reset
//   wr_frame_start  pulse: writer begins a frame
//   wr_frame_done   pulse: writer finished a frame
//   rd_vsync        pulse: display frame boundary
//   wr_base_addr    base address of the buffer being written
//   rd_base_addr    base address of the buffer being displayed
//   wr_buf_idx      buffer being written
//   rd_buf_idx      buffer being displayed
//   wr_busy         writer is mid-frame
//   latest_valid    an unconsumed complete frame exists
//   frames_dropped  saturating count of discarded frames
//   frames_repeated saturating count of vsyncs with no new frame
module frame_buffer_scheduler #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter logic [31:0] FRAME_STRIDE = 32'h0004_0000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_100Mhz,
    input  logic             rst_n,
    input  logic             wr_frame_start,
    input  logic             wr_frame_done,
    input  logic             rd_vsync,
    output logic [31:0]      wr_base_addr,
    output logic [31:0]      rd_base_addr,
    output logic [1:0]       wr_buf_idx,
    output logic [1:0]       rd_buf_idx,
    output logic             wr_busy,
    output logic             latest_valid,
    output logic [CNT_W-1:0] frames_dropped,
    output logic [CNT_W-1:0] frames_repeated
);

    typedef enum logic [0:0] {WIdle, WActive} wr_state_e;

    wr_state_e        st_q, st_d;
    logic [1:0]       rd_idx_q, rd_idx_d;
    logic [1:0]       lt_idx_q, lt_idx_d;
    logic [1:0]       wr_idx_q, wr_idx_d;
    logic             lv_q, lv_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [31:0]      wr_base_q, rd_base_q;
    logic             done_act;
    logic             drop_inc;

    function automatic logic [31:0] addr_of(input logic [1:0] idx);
        return BASE_ADDR + FRAME_STRIDE * {30'd0, idx};
    endfunction

    always_comb begin
        st_d     = st_q;
        rd_idx_d = rd_idx_q;
        lt_idx_d = lt_idx_q;
        wr_idx_d = wr_idx_q;
        lv_d     = lv_q;
        rep_d    = rep_q;
        drop_inc = 1'b0;
        drop_d   = drop_q;
        done_act = (st_q == WActive) && wr_frame_done;

        // Reader side
        if (rd_vsync) begin
            if (done_act) begin
                // Reader grabs the frame that just completed.
                rd_idx_d = wr_idx_q;
                lt_idx_d = rd_idx_q;
                wr_idx_d = lt_idx_q;
                lv_d     = 1'b0;
                drop_inc = lv_q;
                st_d     = WIdle;
            end else if (lv_q) begin
                rd_idx_d = lt_idx_q;
                lt_idx_d = rd_idx_q;
                lv_d     = 1'b0;
            end else if (rep_q != {CNT_W{1'b1}}) begin
                rep_d = rep_q + 1'b1;
            end
        end

        // Writer FSM
        unique case (st_q)
            WIdle: begin
                if (wr_frame_start) begin
                    // The free buffer is the one neither displayed nor latest.
                    wr_idx_d = 2'd3 - rd_idx_d - lt_idx_d;
                    st_d     = WActive;
                end
            end
            WActive: begin
                if (wr_frame_done) begin
                    if (!rd_vsync) begin
                        lt_idx_d = wr_idx_q;
                        // Old latest buffer is now free; keeps indices distinct.
                        wr_idx_d = lt_idx_q;
                        lv_d     = 1'b1;
                        drop_inc = lv_q;
                        st_d     = WIdle;
                    end
                end else if (wr_frame_start) begin
                    drop_inc = 1'b1;
                end
            end
            default: st_d = WIdle;
        endcase

        if (drop_inc && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk_100Mhz) begin
        if (!rst_n) begin
            st_q      <= WIdle;
            rd_idx_q  <= 2'd0;
            lt_idx_q  <= 2'd1;
            wr_idx_q  <= 2'd2;
            lv_q      <= 1'b0;
            drop_q    <= '0;
            rep_q     <= '0;
            wr_base_q <= addr_of(2'd2);
            rd_base_q <= addr_of(2'd0);
        end else begin
            st_q      <= st_d;
            rd_idx_q  <= rd_idx_d;
            lt_idx_q  <= lt_idx_d;
            wr_idx_q  <= wr_idx_d;
            lv_q      <= lv_d;
            drop_q    <= drop_d;
            rep_q     <= rep_d;
            wr_base_q <= addr_of(wr_idx_d);
            rd_base_q <= addr_of(rd_idx_d);
        end
    end

    assign wr_base_addr    = wr_base_q;
    assign rd_base_addr    = rd_base_q;
    assign wr_buf_idx      = wr_idx_q;
    assign rd_buf_idx      = rd_idx_q;
    assign wr_busy         = (st_q == WActive);
    assign latest_valid    = lv_q;
    assign frames_dropped  = drop_q;
    assign frames_repeated = rep_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// tb_frame_buffer_scheduler
//   Directed bench: expectations are queued after each stimulus step and
//   compared against the registered outputs after the clock edge.
module tb_frame_buffer_scheduler;

    localparam int unsigned CNT_W = 4;

    typedef enum int {
        SelWrBase, SelRdBase, SelWrIdx, SelRdIdx, SelBusy, SelLv, SelDrop, SelRep
    } sel_e;

    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    logic             clk_100Mhz = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_frame_start = 1'b0;
    logic             wr_frame_done = 1'b0;
    logic             rd_vsync = 1'b0;
    logic [31:0]      wr_base_addr;
    logic [31:0]      rd_base_addr;
    logic [1:0]       wr_buf_idx;
    logic [1:0]       rd_buf_idx;
    logic             wr_busy;
    logic             latest_valid;
    logic [CNT_W-1:0] frames_dropped;
    logic [CNT_W-1:0] frames_repeated;

    int   n_asserts = 0;
    int   n_fails   = 0;
    exp_t sb[$];

    frame_buffer_scheduler #(
        .BASE_ADDR   (32'h1000_0000),
        .FRAME_STRIDE(32'h0004_0000),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_100Mhz     (clk_100Mhz),
        .rst_n          (rst_n),
        .wr_frame_start (wr_frame_start),
        .wr_frame_done  (wr_frame_done),
        .rd_vsync       (rd_vsync),
        .wr_base_addr   (wr_base_addr),
        .rd_base_addr   (rd_base_addr),
        .wr_buf_idx     (wr_buf_idx),
        .rd_buf_idx     (rd_buf_idx),
        .wr_busy        (wr_busy),
        .latest_valid   (latest_valid),
        .frames_dropped (frames_dropped),
        .frames_repeated(frames_repeated)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    function automatic logic [31:0] obs(input sel_e s);
        case (s)
            SelWrBase: return wr_base_addr;
            SelRdBase: return rd_base_addr;
            SelWrIdx:  return {30'd0, wr_buf_idx};
            SelRdIdx:  return {30'd0, rd_buf_idx};
            SelBusy:   return {31'd0, wr_busy};
            SelLv:     return {31'd0, latest_valid};
            SelDrop:   return {28'd0, frames_dropped};
            default:   return {28'd0, frames_repeated};
        endcase
    endfunction

    task automatic push(input string tag, input sel_e s, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = s;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        logic [31:0] o;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            o = obs(x.sel);
            n_asserts++;
            assert (o === x.exp) else begin
                n_fails++;
                $error("FAIL %s: observed %0h expected %0h", x.tag, o, x.exp);
            end
        end
    endtask

    // One cycle with the given pulses; outputs sampled 1 ns after the edge.
    task automatic step(input logic s, input logic d, input logic v);
        @(negedge clk_100Mhz);
        wr_frame_start = s;
        wr_frame_done  = d;
        rd_vsync       = v;
        @(posedge clk_100Mhz);
        #1;
        wr_frame_start = 1'b0;
        wr_frame_done  = 1'b0;
        rd_vsync       = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk_100Mhz);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk_100Mhz);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push_reset_vals(input string t);
        push({t, "_rd_base"}, SelRdBase, 32'h1000_0000);
        push({t, "_wr_base"}, SelWrBase, 32'h1008_0000);
        push({t, "_rd_idx"},  SelRdIdx,  32'd0);
        push({t, "_wr_idx"},  SelWrIdx,  32'd2);
        push({t, "_lv"},      SelLv,     32'd0);
        push({t, "_busy"},    SelBusy,   32'd0);
        push({t, "_drop"},    SelDrop,   32'd0);
        push({t, "_rep"},     SelRep,    32'd0);
    endtask

    initial begin
        // 1: reset values
        do_reset(2);
        push_reset_vals("rst");
        drain();

        // 2: start, done, vsync, start
        step(1, 0, 0);
        push("t2_start_busy", SelBusy, 32'd1);
        push("t2_start_idx", SelWrIdx, 32'd2);
        drain();
        step(0, 1, 0);
        push("t2_done_lv", SelLv, 32'd1);
        push("t2_done_busy", SelBusy, 32'd0);
        drain();
        step(0, 0, 1);
        push("t2_vs_rd_idx", SelRdIdx, 32'd2);
        push("t2_vs_rd_base", SelRdBase, 32'h1008_0000);
        push("t2_vs_lv", SelLv, 32'd0);
        push("t2_vs_rep", SelRep, 32'd0);
        drain();
        step(1, 0, 0);
        push("t2_wr_idx", SelWrIdx, 32'd1);
        push("t2_wr_base", SelWrBase, 32'h1004_0000);
        drain();

        // 3: vsync twice with no frame
        do_reset(2);
        step(0, 0, 1);
        step(0, 0, 1);
        push("t3_rep", SelRep, 32'd2);
        push("t3_rd_idx", SelRdIdx, 32'd0);
        push("t3_rd_base", SelRdBase, 32'h1000_0000);
        drain();

        // 4: two frames before vsync -> one dropped
        do_reset(2);
        step(1, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        push("t4_wr_idx2", SelWrIdx, 32'd1);
        drain();
        step(0, 1, 0);
        push("t4_drop", SelDrop, 32'd1);
        drain();
        step(0, 0, 1);
        push("t4_rd_idx", SelRdIdx, 32'd1);
        push("t4_rd_base", SelRdBase, 32'h1004_0000);
        push("t4_drop_keep", SelDrop, 32'd1);
        push("t4_rep", SelRep, 32'd0);
        drain();

        // 5: done and vsync together
        do_reset(2);
        step(1, 0, 0);
        step(0, 1, 1);
        push("t5_rd_idx", SelRdIdx, 32'd2);
        push("t5_rd_base", SelRdBase, 32'h1008_0000);
        push("t5_lv", SelLv, 32'd0);
        push("t5_busy", SelBusy, 32'd0);
        push("t5_drop", SelDrop, 32'd0);
        push("t5_rep", SelRep, 32'd0);
        drain();
        step(1, 0, 0);
        push("t5_wr_idx", SelWrIdx, 32'd1);
        drain();

        // Ignored done in idle
        do_reset(2);
        step(0, 1, 0);
        push("idle_done_lv", SelLv, 32'd0);
        push("idle_done_busy", SelBusy, 32'd0);
        push("idle_done_drop", SelDrop, 32'd0);
        drain();

        // 6: restart without done, then mid-frame reset
        step(1, 0, 0);
        step(1, 0, 0);
        push("t6_drop", SelDrop, 32'd1);
        push("t6_wr_idx", SelWrIdx, 32'd2);
        push("t6_busy", SelBusy, 32'd1);
        drain();
        do_reset(1);
        push_reset_vals("t6_rst");
        drain();

        // Counter saturation at all-ones
        for (int i = 0; i < 17; i++) step(0, 0, 1);
        push("sat_rep", SelRep, 32'd15);
        drain();
        step(1, 0, 0);
        for (int i = 0; i < 17; i++) step(1, 0, 0);
        push("sat_drop", SelDrop, 32'd15);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
